// File: rtl/atomrv_pkg.sv
// Shared widths and ALU opcode encoding for the AtomRV execute stage.
package atomrv_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 6;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 6'd0,
        ALU_SUB  = 6'd1,
        ALU_SLL  = 6'd2,
        ALU_SLT  = 6'd3,
        ALU_SLTU = 6'd4,
        ALU_XOR  = 6'd5,
        ALU_SRL  = 6'd6,
        ALU_SRA  = 6'd7,
        ALU_OR   = 6'd8,
        ALU_AND  = 6'd9,
        ALU_BEQ  = 6'd16,
        ALU_BNE  = 6'd17,
        ALU_BLT  = 6'd18,
        ALU_BGE  = 6'd19,
        ALU_BLTU = 6'd20,
        ALU_BGEU = 6'd21
    } alu_op_e;

    // MEM wins over WB because it holds the younger value; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                           input logic [REG_W-1:0] rd_m,
                                           input logic [REG_W-1:0] rd_wb);
        if (rs == rd_m && rd_m != '0)
            return 2'b01;
        else if (rs == rd_wb && rd_wb != '0)
            return 2'b10;
        else
            return 2'b00;
    endfunction

endpackage

// File: rtl/atomrv_core_alu_if.sv
// Execute-stage operand, control and result bundle between decode and the ALU.
interface atomrv_core_alu_if;
    import atomrv_pkg::*;

    logic [OP_W-1:0]   ALUop_i;
    logic [DATA_W-1:0] operand_A;
    logic [DATA_W-1:0] operand_B;
    logic [DATA_W-1:0] operand_B_f_i;
    logic [DATA_W-1:0] PC_i;
    logic [DATA_W-1:0] immed_i;
    logic [DATA_W-1:0] address_i;
    logic [DATA_W-1:0] R2_i;
    logic [REG_W-1:0]  RD_i;
    logic [REG_W-1:0]  RS1_i;
    logic [REG_W-1:0]  RS2_i;
    logic              DR_EN_i;
    logic              DWR_EN_i;
    logic              RWR_EN_i;
    logic              SB_EN_i;
    logic              UJE_i;
    logic              JALRE_i;
    logic              U_EN_i;
    logic              LUI_EN_i;
    logic [REG_W-1:0]  RD_m_i;
    logic [REG_W-1:0]  RD_wb_i;

    logic [DATA_W-1:0] result_o;
    logic [DATA_W-1:0] address_o;
    logic [DATA_W-1:0] PC_o;
    logic              BE_o;
    logic              DR_EN_o;
    logic              DWR_EN_o;
    logic              RWR_EN_o;
    logic [REG_W-1:0]  RD_o;
    logic [DATA_W-1:0] R2_o;
    logic [1:0]        fwd1_o;
    logic [1:0]        fwd2_o;

    modport master (
        output ALUop_i, operand_A, operand_B, operand_B_f_i, PC_i, immed_i,
               address_i, R2_i, RD_i, RS1_i, RS2_i, DR_EN_i, DWR_EN_i,
               RWR_EN_i, SB_EN_i, UJE_i, JALRE_i, U_EN_i, LUI_EN_i,
               RD_m_i, RD_wb_i,
        input  result_o, address_o, PC_o, BE_o, DR_EN_o, DWR_EN_o, RWR_EN_o,
               RD_o, R2_o, fwd1_o, fwd2_o
    );

    modport slave (
        input  ALUop_i, operand_A, operand_B, operand_B_f_i, PC_i, immed_i,
               address_i, R2_i, RD_i, RS1_i, RS2_i, DR_EN_i, DWR_EN_i,
               RWR_EN_i, SB_EN_i, UJE_i, JALRE_i, U_EN_i, LUI_EN_i,
               RD_m_i, RD_wb_i,
        output result_o, address_o, PC_o, BE_o, DR_EN_o, DWR_EN_o, RWR_EN_o,
               RD_o, R2_o, fwd1_o, fwd2_o
    );
endinterface

// File: rtl/atomrv_fwd_unit.sv
// Operand forwarding select for rs1 and rs2 against the MEM and WB destinations.
// Latency: combinational; no backpressure.
module atomrv_fwd_unit
    import atomrv_pkg::*;
(
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_wb,
    output logic [1:0]       fwd1,
    output logic [1:0]       fwd2
);
    assign fwd1 = fwd_sel(rs1, rd_m, rd_wb);
    assign fwd2 = fwd_sel(rs2, rd_m, rd_wb);
endmodule

// File: rtl/atomrv_core_alu.sv
// AtomRV execute stage: ALU, branch/jump target and resolve, load/store address.
// Latency: 1 cycle for all results, forwarding selects combinational; no stall, no backpressure.
module atomrv_core_alu
    import atomrv_pkg::*;
#(
    parameter int DATAWIDTH        = DATA_W,
    parameter int REG_ADRESS_WIDTH = REG_W,
    parameter int ALU_OP           = OP_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    atomrv_core_alu_if.slave alu
);
    localparam int SH_W = $clog2(DATAWIDTH);

    logic [DATAWIDTH-1:0]        a, b, bf;
    logic [SH_W-1:0]             shamt;
    logic [ALU_OP-1:0]           op;
    logic [DATAWIDTH-1:0]        alu_res;
    logic                        cond;
    logic [DATAWIDTH-1:0]        pc_imm, jalr_sum;
    logic [DATAWIDTH-1:0]        res_d, pc_d, addr_d;
    logic                        be_d;
    logic [REG_ADRESS_WIDTH-1:0] rd_d;

    assign a     = alu.operand_A;
    assign b     = alu.operand_B;
    assign bf    = alu.operand_B_f_i;
    assign op    = alu.ALUop_i;
    assign shamt = b[SH_W-1:0];
    assign rd_d  = alu.RD_i;

    always_comb begin
        alu_res = '0;
        cond    = 1'b0;
        case (op)
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_SLL:  alu_res = a << shamt;
            ALU_SLT:  alu_res = {{(DATAWIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_res = {{(DATAWIDTH-1){1'b0}}, a < b};
            ALU_XOR:  alu_res = a ^ b;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            ALU_OR:   alu_res = a | b;
            ALU_AND:  alu_res = a & b;
            ALU_BEQ:  cond = (a == bf);
            ALU_BNE:  cond = (a != bf);
            ALU_BLT:  cond = ($signed(a) <  $signed(bf));
            ALU_BGE:  cond = ($signed(a) >= $signed(bf));
            ALU_BLTU: cond = (a <  bf);
            ALU_BGEU: cond = (a >= bf);
            default: begin
                alu_res = '0;
                cond    = 1'b0;
            end
        endcase
    end

    assign pc_imm   = alu.PC_i + alu.immed_i;
    assign jalr_sum = a + alu.immed_i;

    always_comb begin
        if (alu.LUI_EN_i)
            res_d = alu.immed_i;
        else if (alu.U_EN_i)
            res_d = pc_imm;
        else if (alu.UJE_i || alu.JALRE_i)
            res_d = alu.PC_i + DATAWIDTH'(4);
        else
            res_d = alu_res;

        if (alu.JALRE_i)
            pc_d = {jalr_sum[DATAWIDTH-1:1], 1'b0};
        else if (alu.UJE_i || alu.SB_EN_i)
            pc_d = pc_imm;
        else
            pc_d = '0;

        be_d   = alu.UJE_i | alu.JALRE_i | (alu.SB_EN_i & cond);
        addr_d = (alu.DR_EN_i || alu.DWR_EN_i) ? (a + alu.address_i) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu.result_o  <= '0;
            alu.address_o <= '0;
            alu.PC_o      <= '0;
            alu.BE_o      <= 1'b0;
            alu.DR_EN_o   <= 1'b0;
            alu.DWR_EN_o  <= 1'b0;
            alu.RWR_EN_o  <= 1'b0;
            alu.RD_o      <= '0;
            alu.R2_o      <= '0;
        end else begin
            alu.result_o  <= res_d;
            alu.address_o <= addr_d;
            alu.PC_o      <= pc_d;
            alu.BE_o      <= be_d;
            alu.DR_EN_o   <= alu.DR_EN_i;
            alu.DWR_EN_o  <= alu.DWR_EN_i;
            alu.RWR_EN_o  <= alu.RWR_EN_i;
            alu.RD_o      <= rd_d;
            alu.R2_o      <= alu.R2_i;
        end
    end

    atomrv_fwd_unit u_fwd (
        .rs1   (alu.RS1_i),
        .rs2   (alu.RS2_i),
        .rd_m  (alu.RD_m_i),
        .rd_wb (alu.RD_wb_i),
        .fwd1  (alu.fwd1_o),
        .fwd2  (alu.fwd2_o)
    );
endmodule

// File: tb/tb_atomrv_core_alu.sv
// Bench for atomrv_core_alu: directed corner vectors, reset behaviour and random
// stimulus compared against an arithmetic reference model.
module tb_atomrv_core_alu;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, bf, pc, imm, addr, r2;
        logic [4:0]  rd, rs1, rs2, rd_m, rd_wb;
        logic        dr, dwr, rwr, sb, uje, jalre, u, lui;
    } stim_t;

    typedef struct {
        logic [31:0] result, address, pc, r2;
        logic        be, dr, dwr, rwr;
        logic [4:0]  rd;
        logic [1:0]  fwd1, fwd2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    atomrv_core_alu_if bus();

    atomrv_core_alu dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .alu    (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t zero_stim();
        stim_t s;
        s.op = '0; s.a = '0; s.b = '0; s.bf = '0; s.pc = '0; s.imm = '0;
        s.addr = '0; s.r2 = '0; s.rd = '0; s.rs1 = '0; s.rs2 = '0;
        s.rd_m = '0; s.rd_wb = '0;
        s.dr = 0; s.dwr = 0; s.rwr = 0; s.sb = 0; s.uje = 0; s.jalre = 0;
        s.u = 0; s.lui = 0;
        return s;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] m,
                                           input logic [4:0] wb);
        if (m != 0 && rs == m) return 2'd1;
        if (wb != 0 && rs == wb) return 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] alu_v, ones;
        bit          taken;
        int          sa, sb, sbf;
        int unsigned sh;
        ones  = 32'hFFFF_FFFF;
        sh    = s.b % 32;
        sa    = s.a;
        sb    = s.b;
        sbf   = s.bf;
        alu_v = 0;
        taken = 0;
        case (s.op)
            0:  alu_v = s.a + s.b;
            1:  alu_v = s.a - s.b;
            2:  alu_v = s.a << sh;
            3:  alu_v = (sa < sb) ? 1 : 0;
            4:  alu_v = (s.a < s.b) ? 1 : 0;
            5:  alu_v = s.a ^ s.b;
            6:  alu_v = s.a >> sh;
            7:  alu_v = (s.a >> sh) | (s.a[31] ? ~(ones >> sh) : 32'd0);
            8:  alu_v = s.a | s.b;
            9:  alu_v = s.a & s.b;
            16: taken = (s.a == s.bf);
            17: taken = (s.a != s.bf);
            18: taken = (sa < sbf);
            19: taken = (sa >= sbf);
            20: taken = (s.a < s.bf);
            21: taken = (s.a >= s.bf);
            default: ;
        endcase
        if (s.lui)                  e.result = s.imm;
        else if (s.u)               e.result = s.pc + s.imm;
        else if (s.uje || s.jalre)  e.result = s.pc + 4;
        else                        e.result = alu_v;
        if (s.jalre)                e.pc = (s.a + s.imm) & ~32'd1;
        else if (s.uje || s.sb)     e.pc = s.pc + s.imm;
        else                        e.pc = 0;
        e.be      = s.uje | s.jalre | (s.sb & taken);
        e.address = (s.dr || s.dwr) ? s.a + s.addr : 0;
        e.dr = s.dr; e.dwr = s.dwr; e.rwr = s.rwr; e.rd = s.rd; e.r2 = s.r2;
        e.fwd1 = ref_fwd(s.rs1, s.rd_m, s.rd_wb);
        e.fwd2 = ref_fwd(s.rs2, s.rd_m, s.rd_wb);
        return e;
    endfunction

    task automatic drive(input stim_t s);
        bus.ALUop_i = s.op; bus.operand_A = s.a; bus.operand_B = s.b;
        bus.operand_B_f_i = s.bf; bus.PC_i = s.pc; bus.immed_i = s.imm;
        bus.address_i = s.addr; bus.R2_i = s.r2; bus.RD_i = s.rd;
        bus.RS1_i = s.rs1; bus.RS2_i = s.rs2; bus.RD_m_i = s.rd_m; bus.RD_wb_i = s.rd_wb;
        bus.DR_EN_i = s.dr; bus.DWR_EN_i = s.dwr; bus.RWR_EN_i = s.rwr;
        bus.SB_EN_i = s.sb; bus.UJE_i = s.uje; bus.JALRE_i = s.jalre;
        bus.U_EN_i = s.u; bus.LUI_EN_i = s.lui;
    endtask

    task automatic check_regs(input exp_t e, input string tag);
        check_eq({tag, ".result"},  bus.result_o,  e.result);
        check_eq({tag, ".address"}, bus.address_o, e.address);
        check_eq({tag, ".pc"},      bus.PC_o,      e.pc);
        check_eq({tag, ".be"},      32'(bus.BE_o),     32'(e.be));
        check_eq({tag, ".dr"},      32'(bus.DR_EN_o),  32'(e.dr));
        check_eq({tag, ".dwr"},     32'(bus.DWR_EN_o), 32'(e.dwr));
        check_eq({tag, ".rwr"},     32'(bus.RWR_EN_o), 32'(e.rwr));
        check_eq({tag, ".rd"},      32'(bus.RD_o),     32'(e.rd));
        check_eq({tag, ".r2"},      bus.R2_o,      e.r2);
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = model(zero_stim());
        check_regs(z, tag);
    endtask

    // Drive on the falling edge, check forwarding combinationally, then the
    // registered outputs just after the next rising edge.
    task automatic run_vec(input stim_t s, input string tag);
        exp_t e;
        e = model(s);
        @(negedge clk);
        drive(s);
        #1;
        check_eq({tag, ".fwd1"}, 32'(bus.fwd1_o), 32'(e.fwd1));
        check_eq({tag, ".fwd2"}, 32'(bus.fwd2_o), 32'(e.fwd2));
        @(posedge clk);
        #1;
        check_regs(e, tag);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
            2:       return 32'h8000_0000 ^ 32'($urandom_range(0, 8));
            default: return $urandom;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = zero_stim();
        s.op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 23));
        s.a     = rand_val();
        s.b     = rand_val();
        s.bf    = ($urandom_range(0, 2) == 0) ? s.a : rand_val();
        s.pc    = $urandom & 32'hFFFF_FFFC;
        s.imm   = rand_val();
        s.addr  = rand_val();
        s.r2    = $urandom;
        s.rd    = 5'($urandom);
        s.rs1   = 5'($urandom_range(0, 3));
        s.rs2   = 5'($urandom_range(0, 3));
        s.rd_m  = 5'($urandom_range(0, 3));
        s.rd_wb = 5'($urandom_range(0, 3));
        s.dr    = ($urandom_range(0, 3) == 0);
        s.dwr   = ($urandom_range(0, 3) == 0);
        s.rwr   = $urandom_range(0, 1) == 1;
        s.sb    = ($urandom_range(0, 2) == 0);
        s.uje   = ($urandom_range(0, 7) == 0);
        s.jalre = ($urandom_range(0, 7) == 0);
        s.u     = ($urandom_range(0, 7) == 0);
        s.lui   = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        exp_t  e;
        drive(zero_stim());
        #2;
        check_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        s = zero_stim(); s.a = 5; s.b = 7;
        run_vec(s, "add");
        s = zero_stim(); s.op = 1; s.a = 3; s.b = 5;
        run_vec(s, "sub");
        s = zero_stim(); s.op = 7; s.a = 32'h8000_0000; s.b = 4;
        run_vec(s, "sra");
        s.op = 6;
        run_vec(s, "srl");
        s = zero_stim(); s.op = 4; s.a = 1; s.b = 32'hFFFF_FFFF;
        run_vec(s, "sltu");
        s.op = 3;
        run_vec(s, "slt");
        s = zero_stim(); s.op = 16; s.sb = 1; s.a = 9; s.bf = 9; s.pc = 32'h100; s.imm = 32'h20;
        run_vec(s, "beq_taken");
        s.bf = 8;
        run_vec(s, "beq_not");
        s = zero_stim(); s.jalre = 1; s.a = 32'h1003; s.imm = 4; s.pc = 32'h100;
        run_vec(s, "jalr");
        s = zero_stim(); s.lui = 1; s.imm = 32'hABCD_E000; s.u = 1; s.pc = 32'h40;
        run_vec(s, "lui");
        s = zero_stim(); s.op = 6'd63; s.a = 32'h1234; s.b = 32'h55; s.sb = 1; s.bf = 32'h1234;
        run_vec(s, "bad_op");
        s = zero_stim(); s.dwr = 1; s.a = 32'h1000; s.addr = 32'hFFFF_FFF8;
        s.r2 = 32'hCAFE_F00D; s.rd = 5'd17; s.rwr = 1;
        run_vec(s, "store_addr");
        s = zero_stim(); s.rs1 = 5; s.rd_m = 5; s.rd_wb = 5; s.rs2 = 6;
        run_vec(s, "fwd_mem_pri");
        s = zero_stim(); s.rs2 = 6; s.rd_wb = 6; s.rd_m = 3;
        run_vec(s, "fwd_wb");
        s = zero_stim(); s.rs1 = 0; s.rd_m = 0; s.rs2 = 0; s.rd_wb = 0;
        run_vec(s, "fwd_x0");

        // Asynchronous reset landing between edges after a non-zero result.
        s = zero_stim(); s.a = 5; s.b = 7; s.rwr = 1; s.rd = 3; s.r2 = 32'h77;
        run_vec(s, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        e = model(s);
        @(posedge clk);
        #1;
        check_regs(e, "rst_release");

        for (int i = 0; i < 400; i++) begin
            s = rand_stim();
            run_vec(s, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atomrv_core_alu.md
ATOMRV_CORE_ALU -- requirements
Module: atomrv_core_alu

Interface
REQ-001 The block SHALL have parameters DATAWIDTH=32 (data/address width), REG_ADRESS_WIDTH=5 (register index width) and ALU_OP=6 (opcode width).
REQ-002 The block SHALL have a single clock and an asynchronous active-low reset, with these ports:
- clk_i in 1: clock, rising edge.
- rst_ni in 1: asynchronous active-low reset.
REQ-003 The operand inputs SHALL be:
- ALUop_i in 6: operation select.
- operand_A in 32: rs1 value.
- operand_B in 32: rs2 or immediate (ALU second operand).
- operand_B_f_i in 32: rs2 value, used for branch compare.
REQ-004 The pipeline inputs SHALL be:
- PC_i in 32: PC of the instruction.
- immed_i in 32: sign-extended immediate.
- address_i in 32: load/store offset.
- R2_i in 32: store data.
- RD_i, RS1_i, RS2_i in 5 each: destination and source register indexes.
REQ-005 The control inputs SHALL be DR_EN_i, DWR_EN_i, RWR_EN_i, SB_EN_i, UJE_i, JALRE_i, U_EN_i, LUI_EN_i, each in 1: load, store, register-write, branch, JAL, JALR, AUIPC and LUI respectively.
REQ-006 The forwarding inputs SHALL be RD_m_i and RD_wb_i, in 5 each: rd of the instructions currently in the MEM and WB stages.
REQ-007 The outputs SHALL be:
- result_o out 32.
- address_o out 32.
- PC_o out 32: branch/jump target.
- BE_o out 1: redirect taken.
- DR_EN_o, DWR_EN_o, RWR_EN_o out 1 each.
- RD_o out 5.
- R2_o out 32.
- fwd1_o, fwd2_o out 2 each.

Function
REQ-008 All outputs except fwd1_o and fwd2_o SHALL be registered on the rising edge of clk_i, giving 1-cycle latency, with no stall or enable input.
REQ-009 ALUop_i SHALL be decoded as:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, each computed on operand_A and operand_B.
- 16 BEQ, 17 BNE, 18 BLT, 19 BGE, 20 BLTU, 21 BGEU, each comparing operand_A with operand_B_f_i.
- Any other code SHALL give result 0 and condition false.
REQ-010 Arithmetic SHALL be modulo 2^32; shift amount SHALL be operand_B[4:0]; SRA SHALL sign-fill; SLT/BLT/BGE SHALL be signed; SLTU/BLTU/BGEU SHALL be unsigned; SLT/SLTU SHALL produce 0 or 1.
REQ-011 result_o SHALL be selected by priority:
- LUI_EN_i: immed_i.
- U_EN_i: PC_i+immed_i.
- UJE_i or JALRE_i: PC_i+4.
- Otherwise: the ALU result.
REQ-012 PC_o SHALL be:
- JALRE_i: (operand_A+immed_i) with bit0 cleared.
- UJE_i or SB_EN_i: PC_i+immed_i.
- Otherwise: 0.
REQ-013 BE_o SHALL equal UJE_i | JALRE_i | (SB_EN_i & branch condition true); a not-taken branch SHALL give BE_o=0.
REQ-014 address_o SHALL be operand_A+address_i when DR_EN_i or DWR_EN_i is set, else 0.
REQ-015 RD_o, RWR_EN_o, DR_EN_o, DWR_EN_o and R2_o SHALL register their inputs unchanged; the block SHALL perform no flush or squash.
REQ-016 fwd1_o SHALL be combinational:
- 2'b01 if RS1_i==RD_m_i and RD_m_i!=0.
- Else 2'b10 if RS1_i==RD_wb_i and RD_wb_i!=0.
- Else 2'b00.
fwd2_o SHALL be identical using RS2_i.
REQ-017 A simultaneous MEM and WB match SHALL select MEM (2'b01); a match on x0 SHALL never forward.

Reset
REQ-018 While rst_ni=0, all registered outputs SHALL be 0 immediately, regardless of clk_i.
REQ-019 When reset is asserted mid-operation, in-flight results SHALL be discarded; the first capture SHALL occur on the first rising edge after rst_ni rises.

Structure
REQ-020 A shared package atomrv_pkg SHALL hold the width constants and the ALUop enumeration from REQ-009.
REQ-021 Forwarding logic SHALL be one sub-module, atomrv_fwd_unit, instantiated once with two port pairs (RS1 and RS2).

Verification
REQ-022 ADD: ALUop=0, A=5, B=7 -> result_o=12 one cycle later; SUB: A=3, B=5 -> 0xFFFFFFFE.
REQ-023 Shifts: SRA with A=0x80000000, B=4 -> 0xF8000000; SRL with the same operands -> 0x08000000; SLTU with A=1, B=0xFFFFFFFF -> 1.
REQ-024 BEQ taken: SB_EN=1, ALUop=16, A=B_f=9, PC=0x100, imm=0x20 -> BE_o=1, PC_o=0x120; with B_f=8 -> BE_o=0.
REQ-025 JALR: JALRE=1, A=0x1003, imm=4, PC=0x100 -> PC_o=0x1006, result_o=0x104, BE_o=1; LUI with imm=0xABCDE000 -> result_o=0xABCDE000.
REQ-026 Forwarding:
- RS1=5, RD_m=5, RD_wb=5 -> fwd1_o=01.
- RS2=6, RD_wb=6 -> fwd2_o=10.
- RS1=0, RD_m=0 -> fwd1_o=00.
REQ-027 Reset: drive rst_ni low between clock edges after a non-zero result -> all registered outputs read 0 before the next edge.
